// File: rtl/convolution_pkg.sv
// Shared types and widths for the convolution scheduler and its helpers.
package convolution_pkg;

    localparam int IR_ADDR_W = 15;
    localparam int RESULT_W  = 48;
    localparam int SAMPLE_W  = 16;

    typedef enum logic [2:0] {
        LOAD,
        WAIT_SAMPLE,
        BUSY,
        OUTPUT,
        RELOAD
    } sched_state_t;

endpackage

// File: rtl/result_saturator.sv
// Scales the 48-bit engine result down by OUT_SHIFT and clamps it to a 16-bit sample.
module result_saturator
    import convolution_pkg::*;
#(
    parameter int OUT_SHIFT = 15
) (
    input  logic [RESULT_W-1:0] result,
    output logic [SAMPLE_W-1:0] sample
);

    localparam logic signed [RESULT_W-1:0] SAT_MAX = RESULT_W'(32767);
    localparam logic signed [RESULT_W-1:0] SAT_MIN = -(RESULT_W'(32768));

    function automatic logic [SAMPLE_W-1:0] clamp_sample(input logic signed [RESULT_W-1:0] s);
        if (s > SAT_MAX) begin
            return 16'h7FFF;
        end else if (s < SAT_MIN) begin
            return 16'h8000;
        end else begin
            return s[SAMPLE_W-1:0];
        end
    endfunction

    logic signed [RESULT_W-1:0] shifted;

    // Sign-preserving shift followed by clamp to the 16-bit range
    always_comb begin
        shifted = $signed(result) >>> OUT_SHIFT;
        sample  = clamp_sample(shifted);
    end

endmodule

// File: rtl/convolution_scheduler.sv
// Sequences the IR convolution engine: IR load, per-sample trigger/result
// handling, overrun/timeout accounting and IR reloads between convolutions.
module convolution_scheduler
    import convolution_pkg::*;
#(
    parameter int IMPULSE_LENGTH = 24000,
    parameter int OUT_SHIFT      = 15,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                 audio_clk,
    input  logic                 rst_in,
    input  logic                 ir_valid,
    input  logic [15:0]          ir_data,
    output logic                 ir_ready,
    output logic                 ir_wr_en,
    output logic [14:0]          ir_wr_addr,
    output logic [15:0]          ir_wr_data,
    output logic                 impulse_ready,
    input  logic                 reload_req,
    input  logic                 sample_strobe,
    input  logic [15:0]          sample_in,
    output logic                 conv_trigger,
    output logic [15:0]          conv_audio,
    output logic                 conv_rst,
    input  logic                 conv_done,
    input  logic [47:0]          conv_result,
    output logic [15:0]          audio_out,
    output logic                 audio_out_valid,
    output logic [15:0]          overrun_count,
    output logic [7:0]           timeout_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IR_ADDR_W-1:0] LAST_ADDR = IR_ADDR_W'(IMPULSE_LENGTH - 1);
    localparam logic [TMR_W-1:0]     TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    sched_state_t state, state_next;

    logic [IR_ADDR_W-1:0] load_addr, load_addr_d;
    logic                 last_wr, last_wr_d;
    logic                 reload_pend, reload_pend_d;
    logic [TMR_W-1:0]     cycle_cnt, cycle_cnt_d;
    logic [RESULT_W-1:0]  result_q, result_q_d;
    logic [SAMPLE_W-1:0]  sat_sample;

    logic                 ir_ready_d, ir_wr_en_d, impulse_ready_d;
    logic [14:0]          ir_wr_addr_d;
    logic [15:0]          ir_wr_data_d;
    logic                 conv_trigger_d, conv_rst_d, audio_out_valid_d;
    logic [15:0]          conv_audio_d, audio_out_d, overrun_count_d;
    logic [7:0]           timeout_count_d;

    logic ir_hs, ir_hs_last, reload_any, timed_out;

    assign ir_hs      = (state == LOAD) && ir_valid && ir_ready;
    assign ir_hs_last = ir_hs && (load_addr == LAST_ADDR);
    assign reload_any = reload_pend || reload_req;
    assign timed_out  = (state == BUSY) && !conv_done && (cycle_cnt == TMR_LAST);

    result_saturator #(.OUT_SHIFT(OUT_SHIFT)) u_sat (
        .result (result_q),
        .sample (sat_sample)
    );

    // State register
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) state <= LOAD;
        else        state <= state_next;
    end

    // Next-state decision; reloads only act outside an in-flight convolution
    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (reload_any)   state_next = RELOAD;
                else if (last_wr) state_next = WAIT_SAMPLE;
            end
            WAIT_SAMPLE: begin
                if (reload_any)         state_next = RELOAD;
                else if (sample_strobe) state_next = BUSY;
            end
            BUSY: begin
                if (conv_done)      state_next = OUTPUT;
                else if (timed_out) state_next = reload_any ? RELOAD : WAIT_SAMPLE;
            end
            OUTPUT:  state_next = reload_any ? RELOAD : WAIT_SAMPLE;
            RELOAD:  state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Next values of all registered outputs and bookkeeping
    always_comb begin
        ir_wr_en_d        = ir_hs;
        ir_wr_addr_d      = ir_hs ? load_addr : ir_wr_addr;
        ir_wr_data_d      = ir_hs ? ir_data : ir_wr_data;
        last_wr_d         = ir_hs_last;
        ir_ready_d        = (state_next == LOAD) && !ir_hs_last;
        load_addr_d       = load_addr;
        if (state_next == RELOAD) load_addr_d = '0;
        else if (ir_hs)           load_addr_d = load_addr + 1'b1;

        impulse_ready_d   = impulse_ready;
        if (state_next == RELOAD)
            impulse_ready_d = 1'b0;
        else if (state == LOAD && state_next == WAIT_SAMPLE)
            impulse_ready_d = 1'b1;

        conv_rst_d        = (state_next == RELOAD);
        reload_pend_d     = (state_next == RELOAD) ? 1'b0 : reload_any;

        conv_trigger_d    = (state == WAIT_SAMPLE) && (state_next == BUSY);
        conv_audio_d      = conv_trigger_d ? sample_in : conv_audio;
        cycle_cnt_d       = (state == BUSY) ? cycle_cnt + 1'b1 : '0;
        result_q_d        = (state == BUSY && conv_done) ? conv_result : result_q;

        audio_out_d       = (state == OUTPUT) ? sat_sample : audio_out;
        audio_out_valid_d = (state == OUTPUT) || timed_out;

        overrun_count_d   = overrun_count;
        if (state == BUSY && sample_strobe && overrun_count != 16'hFFFF)
            overrun_count_d = overrun_count + 1'b1;

        timeout_count_d   = timeout_count;
        if (timed_out && timeout_count != 8'hFF)
            timeout_count_d = timeout_count + 1'b1;
    end

    // Output and control registers, all cleared by reset
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            ir_ready        <= 1'b0;
            ir_wr_en        <= 1'b0;
            ir_wr_addr      <= '0;
            ir_wr_data      <= '0;
            impulse_ready   <= 1'b0;
            conv_trigger    <= 1'b0;
            conv_audio      <= '0;
            conv_rst        <= 1'b0;
            audio_out       <= '0;
            audio_out_valid <= 1'b0;
            overrun_count   <= '0;
            timeout_count   <= '0;
            load_addr       <= '0;
            last_wr         <= 1'b0;
            reload_pend     <= 1'b0;
            cycle_cnt       <= '0;
        end else begin
            ir_ready        <= ir_ready_d;
            ir_wr_en        <= ir_wr_en_d;
            ir_wr_addr      <= ir_wr_addr_d;
            ir_wr_data      <= ir_wr_data_d;
            impulse_ready   <= impulse_ready_d;
            conv_trigger    <= conv_trigger_d;
            conv_audio      <= conv_audio_d;
            conv_rst        <= conv_rst_d;
            audio_out       <= audio_out_d;
            audio_out_valid <= audio_out_valid_d;
            overrun_count   <= overrun_count_d;
            timeout_count   <= timeout_count_d;
            load_addr       <= load_addr_d;
            last_wr         <= last_wr_d;
            reload_pend     <= reload_pend_d;
            cycle_cnt       <= cycle_cnt_d;
        end
    end

    // Captured engine result; pure data, so no reset
    always_ff @(posedge audio_clk) begin
        result_q <= result_q_d;
    end

endmodule
